// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one asynchronous boot ROM between the cpu fetch path and the dma copy engine.
// Optional round-robin arbitration is enabled by defining ROM_ARB_RR_EN; otherwise cpu has fixed priority.
module rom_access_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce_n,
    input  logic [7:0]        rom_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t            r_state, w_state_nx;
    logic [3:0]        r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_ce_n, w_ce_n_nx;
    logic              r_win_dma, w_win_dma_nx;
    logic              r_cpu_ack, w_cpu_ack_nx;
    logic              r_dma_ack, w_dma_ack_nx;
    logic [7:0]        r_cpu_rdata, w_cpu_rdata_nx;
    logic [7:0]        r_dma_rdata, w_dma_rdata_nx;
    logic              w_any_req;
    logic              w_pick_dma;

    assign w_any_req = cpu_req | dma_req;

`ifdef ROM_ARB_RR_EN
    logic r_last_dma;

    // On a tie, grant whichever requester did not win last; a lone request always wins.
    assign w_pick_dma = dma_req & (~cpu_req | ~r_last_dma);

    // Remember the most recent winner; reset favours cpu on the first tie.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst)
            r_last_dma <= 1'b1;
        else if (r_state == S_IDLE && w_any_req)
            r_last_dma <= w_pick_dma;
    end
`else
    assign w_pick_dma = dma_req & ~cpu_req;
`endif

    // State register.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next state plus next values of the ROM bus, wait counter, acks and read data.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_addr_nx      = r_addr;
        w_ce_n_nx      = r_ce_n;
        w_win_dma_nx   = r_win_dma;
        w_cpu_ack_nx   = 1'b0;
        w_dma_ack_nx   = 1'b0;
        w_cpu_rdata_nx = r_cpu_rdata;
        w_dma_rdata_nx = r_dma_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nx   = S_ACCESS;
                    w_addr_nx    = w_pick_dma ? dma_addr : cpu_addr;
                    w_ce_n_nx    = 1'b0;
                    w_cnt_nx     = 4'(WAIT_CYCLES);
                    w_win_dma_nx = w_pick_dma;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_state_nx = S_RECOVER;
                    w_ce_n_nx  = 1'b1;
                    if (r_win_dma) begin
                        w_dma_ack_nx   = 1'b1;
                        w_dma_rdata_nx = rom_data;
                    end else begin
                        w_cpu_ack_nx   = 1'b1;
                        w_cpu_rdata_nx = rom_data;
                    end
                end
            end
            S_RECOVER: w_state_nx = S_IDLE;
            default: begin
                w_state_nx = S_IDLE;
                w_ce_n_nx  = 1'b1;
            end
        endcase
    end

    // Registered datapath; reset drops chip enable at once and leaves read data at 0xFF.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_win_dma   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_cpu_rdata <= 8'hFF;
            r_dma_rdata <= 8'hFF;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_addr      <= w_addr_nx;
            r_ce_n      <= w_ce_n_nx;
            r_win_dma   <= w_win_dma_nx;
            r_cpu_ack   <= w_cpu_ack_nx;
            r_dma_ack   <= w_dma_ack_nx;
            r_cpu_rdata <= w_cpu_rdata_nx;
            r_dma_rdata <= w_dma_rdata_nx;
        end
    end

    assign rom_addr  = r_addr;
    assign rom_ce_n  = r_ce_n;
    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: directed checks of arbitration, access timing, reset abort and read data.
module tb_rom_access_arbiter;

    logic        fclk = 1'b0;
    logic        rst  = 1'b1;

    logic        a_cpu_req = 1'b0, a_dma_req = 1'b0;
    logic [15:0] a_cpu_addr = '0, a_dma_addr = '0;
    logic        a_cpu_ack, a_dma_ack, a_rom_ce_n, a_busy;
    logic [7:0]  a_cpu_rdata, a_dma_rdata, a_rom_data;
    logic [15:0] a_rom_addr;

    logic        b_cpu_req = 1'b0, b_dma_req = 1'b0;
    logic [15:0] b_cpu_addr = '0, b_dma_addr = '0;
    logic        b_cpu_ack, b_dma_ack, b_rom_ce_n, b_busy;
    logic [7:0]  b_cpu_rdata, b_dma_rdata, b_rom_data;
    logic [15:0] b_rom_addr;

    int tests = 0;
    int fails = 0;

    always #5 fclk = ~fclk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 8'h21;
            16'h0005: rom = 8'h60;
            16'h000D: rom = 8'h60;
            default:  rom = 8'hFF;
        endcase
    endfunction

    // Bus value while deselected is 0x00 so any sample with ce_n high shows up as wrong data.
    assign a_rom_data = a_rom_ce_n ? 8'h00 : rom(a_rom_addr);
    assign b_rom_data = b_rom_ce_n ? 8'h00 : rom(b_rom_addr);

    rom_access_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16)) u_a (
        .fclk(fclk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_addr(a_cpu_addr), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .dma_req(a_dma_req), .dma_addr(a_dma_addr), .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
        .rom_addr(a_rom_addr), .rom_ce_n(a_rom_ce_n), .rom_data(a_rom_data), .busy(a_busy)
    );

    rom_access_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16)) u_b (
        .fclk(fclk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_addr(b_cpu_addr), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dma_req(b_dma_req), .dma_addr(b_dma_addr), .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .rom_addr(b_rom_addr), .rom_ce_n(b_rom_ce_n), .rom_data(b_rom_data), .busy(b_busy)
    );

    task automatic tick;
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_ce_n", 32'(a_rom_ce_n), 1);
        chk("rst_addr", 32'(a_rom_addr), 0);
        chk("rst_cpu_ack", 32'(a_cpu_ack), 0);
        chk("rst_dma_ack", 32'(a_dma_ack), 0);
        chk("rst_cpu_rdata", 32'(a_cpu_rdata), 32'hFF);
        chk("rst_dma_rdata", 32'(a_dma_rdata), 32'hFF);
        chk("rst_busy", 32'(a_busy), 0);
        #3 rst = 1'b0;
        tick;
        chk("idle_ce_n", 32'(a_rom_ce_n), 1);
        chk("idle_busy", 32'(a_busy), 0);

        // Test 1: WAIT=2 cpu read of 0x0000
        a_cpu_addr = 16'h0000;
        a_cpu_req  = 1'b1;
        tick;
        chk("t1_e0_ce_n", 32'(a_rom_ce_n), 0);
        chk("t1_e0_busy", 32'(a_busy), 1);
        chk("t1_e0_addr", 32'(a_rom_addr), 0);
        tick;
        chk("t1_e1_ce_n", 32'(a_rom_ce_n), 0);
        chk("t1_e1_ack", 32'(a_cpu_ack), 0);
        tick;
        chk("t1_e2_ce_n", 32'(a_rom_ce_n), 0);
        chk("t1_e2_ack", 32'(a_cpu_ack), 0);
        tick;
        chk("t1_e3_ack", 32'(a_cpu_ack), 1);
        chk("t1_e3_rdata", 32'(a_cpu_rdata), 32'h21);
        chk("t1_e3_ce_n", 32'(a_rom_ce_n), 1);
        chk("t1_e3_busy", 32'(a_busy), 1);
        chk("t1_e3_dma_ack", 32'(a_dma_ack), 0);
        chk("t1_e3_dma_rdata", 32'(a_dma_rdata), 32'hFF);
        a_cpu_req = 1'b0;
        tick;
        chk("t1_e4_ack", 32'(a_cpu_ack), 0);
        chk("t1_e4_busy", 32'(a_busy), 0);
        chk("t1_e4_rdata_hold", 32'(a_cpu_rdata), 32'h21);

        // Test 2: WAIT=0 back-to-back dma reads
        b_dma_addr = 16'h0005;
        b_dma_req  = 1'b1;
        tick;
        chk("t2_e0_ce_n", 32'(b_rom_ce_n), 0);
        tick;
        chk("t2_e1_ack", 32'(b_dma_ack), 1);
        chk("t2_e1_rdata", 32'(b_dma_rdata), 32'h60);
        chk("t2_e1_ce_n", 32'(b_rom_ce_n), 1);
        b_dma_addr = 16'h000D;
        tick;
        chk("t2_e2_ack", 32'(b_dma_ack), 0);
        chk("t2_e2_ce_n", 32'(b_rom_ce_n), 1);
        tick;
        chk("t2_e3_ack", 32'(b_dma_ack), 0);
        chk("t2_e3_ce_n", 32'(b_rom_ce_n), 0);
        chk("t2_e3_addr", 32'(b_rom_addr), 32'h000D);
        tick;
        chk("t2_e4_ack", 32'(b_dma_ack), 1);
        chk("t2_e4_rdata", 32'(b_dma_rdata), 32'h60);
        chk("t2_cpu_rdata_hold", 32'(b_cpu_rdata), 32'hFF);
        b_dma_req = 1'b0;
        tick;
        chk("t2_e5_ack", 32'(b_dma_ack), 0);
        tick;

        // Test 3: simultaneous requests, then a second tie while cpu re-requests
        a_cpu_addr = 16'h0000;
        a_dma_addr = 16'h0005;
        a_cpu_req  = 1'b1;
        a_dma_req  = 1'b1;
        tick;
        chk("t3_tie1_addr", 32'(a_rom_addr), 32'h0000);
        tick;
        tick;
        tick;
        chk("t3_tie1_cpu_ack", 32'(a_cpu_ack), 1);
        chk("t3_tie1_dma_ack", 32'(a_dma_ack), 0);
        chk("t3_tie1_cpu_rdata", 32'(a_cpu_rdata), 32'h21);
        a_cpu_addr = 16'h002B;
        tick;
        tick;
`ifdef ROM_ARB_RR_EN
        chk("t3_tie2_addr", 32'(a_rom_addr), 32'h0005);
        tick;
        tick;
        tick;
        chk("t3_tie2_dma_ack", 32'(a_dma_ack), 1);
        chk("t3_tie2_cpu_ack", 32'(a_cpu_ack), 0);
        chk("t3_tie2_dma_rdata", 32'(a_dma_rdata), 32'h60);
        a_dma_req = 1'b0;
        tick;
        tick;
        chk("t3_last_addr", 32'(a_rom_addr), 32'h002B);
        tick;
        tick;
        tick;
        chk("t3_last_cpu_ack", 32'(a_cpu_ack), 1);
        chk("t3_last_cpu_rdata", 32'(a_cpu_rdata), 32'hFF);
        a_cpu_req = 1'b0;
`else
        chk("t3_tie2_addr", 32'(a_rom_addr), 32'h002B);
        tick;
        tick;
        tick;
        chk("t3_tie2_cpu_ack", 32'(a_cpu_ack), 1);
        chk("t3_tie2_dma_ack", 32'(a_dma_ack), 0);
        chk("t3_tie2_cpu_rdata", 32'(a_cpu_rdata), 32'hFF);
        chk("t3_tie2_dma_rdata_hold", 32'(a_dma_rdata), 32'hFF);
        a_cpu_req = 1'b0;
        tick;
        tick;
        chk("t3_last_addr", 32'(a_rom_addr), 32'h0005);
        tick;
        tick;
        tick;
        chk("t3_last_dma_ack", 32'(a_dma_ack), 1);
        chk("t3_last_dma_rdata", 32'(a_dma_rdata), 32'h60);
        a_dma_req = 1'b0;
`endif
        tick;
        tick;
        chk("t3_idle_busy", 32'(a_busy), 0);

        // Test 6: cpu_req dropped after one ACCESS cycle still completes with one ack
        a_cpu_addr = 16'h0000;
        a_cpu_req  = 1'b1;
        tick;
        tick;
        a_cpu_req = 1'b0;
        chk("t6_e1_ce_n", 32'(a_rom_ce_n), 0);
        tick;
        chk("t6_e2_ack", 32'(a_cpu_ack), 0);
        tick;
        chk("t6_e3_ack", 32'(a_cpu_ack), 1);
        chk("t6_e3_rdata", 32'(a_cpu_rdata), 32'h21);
        tick;
        chk("t6_e4_ack", 32'(a_cpu_ack), 0);
        tick;
        chk("t6_e5_ack", 32'(a_cpu_ack), 0);
        chk("t6_e5_busy", 32'(a_busy), 0);

        // Test 4: unmapped address reads 0xFF
        a_cpu_addr = 16'h3000;
        a_cpu_req  = 1'b1;
        tick;
        chk("t4_addr", 32'(a_rom_addr), 32'h3000);
        tick;
        tick;
        tick;
        chk("t4_ack", 32'(a_cpu_ack), 1);
        chk("t4_rdata", 32'(a_cpu_rdata), 32'hFF);
        a_cpu_req = 1'b0;
        tick;
        tick;

        // Test 5: reset in the middle of an access
        a_cpu_addr = 16'h0005;
        a_cpu_req  = 1'b1;
        tick;
        tick;
        chk("t5_pre_ce_n", 32'(a_rom_ce_n), 0);
        a_cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_ce_n", 32'(a_rom_ce_n), 1);
        chk("t5_busy", 32'(a_busy), 0);
        chk("t5_ack", 32'(a_cpu_ack), 0);
        chk("t5_rdata", 32'(a_cpu_rdata), 32'hFF);
        chk("t5_addr", 32'(a_rom_addr), 0);
        #3 rst = 1'b0;
        tick;
        tick;
        tick;
        chk("t5_post_ack", 32'(a_cpu_ack), 0);
        chk("t5_post_busy", 32'(a_busy), 0);
        chk("t5_post_rdata", 32'(a_cpu_rdata), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
